// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing operand/result capture stage.
// Default widths, flag bit positions, snapshot layout and skid-buffer states.
package dp_pkg;

    localparam int DP_DATA_W  = 32;
    localparam int DP_NUM_OPS = 3;
    localparam int DP_FLAG_W  = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [DP_NUM_OPS-1:0][DP_DATA_W-1:0] ops;
        logic [DP_DATA_W-1:0]                 f;
        logic [DP_FLAG_W-1:0]                 nzcv;
    } snapshot_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/dp_skid_buf.sv
// Generic 2-entry valid/ready queue. in_ready is a flop so the upstream
// never sees a combinational path from out_ready.
module dp_skid_buf
    import dp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    buf_state_e        state_q, state_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0][W-1:0] mem_q;
    logic              push, pop;

    assign push        = in_valid_i && in_ready_q;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = out_valid_o ? mem_q[head_q] : '0;
    assign in_ready_o  = in_ready_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        case (state_q)
            BUF_EMPTY: if (push) state_d = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_d = BUF_FULL;
                else if (pop && !push) state_d = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
        // Ready for next cycle is decided from where this cycle lands.
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            in_ready_q <= 1'b1;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            if (push) mem_q[tail_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/dp_operand_stage.sv
// Operand/result capture stage: merges selectively loaded operands, result and
// masked flags into a running snapshot and queues each snapshot downstream.
module dp_operand_stage
    import dp_pkg::*;
#(
    parameter int DATA_W  = DP_DATA_W,
    parameter int NUM_OPS = DP_NUM_OPS,
    parameter int FLAG_W  = DP_FLAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS-1:0]        ld_op,
    input  logic [NUM_OPS*DATA_W-1:0] r_data,
    input  logic                      ld_f,
    input  logic [DATA_W-1:0]         f_new,
    input  logic                      s,
    input  logic [FLAG_W-1:0]         nzcv_mask,
    input  logic [FLAG_W-1:0]         nzcv_new,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] ops,
    output logic [DATA_W-1:0]         f,
    output logic [FLAG_W-1:0]         nzcv,
    output logic [FLAG_W-1:0]         nzcv_live
);

    localparam int PAY_W = NUM_OPS*DATA_W + DATA_W + FLAG_W;

    logic [NUM_OPS-1:0][DATA_W-1:0] ops_q, ops_d;
    logic [DATA_W-1:0]              f_q, f_d;
    logic [FLAG_W-1:0]              nzcv_q, nzcv_d;
    logic [FLAG_W-1:0]              flag_wr;
    logic [PAY_W-1:0]               head_data;
    logic                           accept;

    assign accept = in_valid && in_ready;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        assign ops_d[i] = ld_op[i] ? r_data[i*DATA_W +: DATA_W] : ops_q[i];
    end

    assign f_d     = ld_f ? f_new : f_q;
    // Flags only move when the instruction sets them (S) and the bit is masked in.
    assign flag_wr = {FLAG_W{s}} & nzcv_mask;
    assign nzcv_d  = (nzcv_new & flag_wr) | (nzcv_q & ~flag_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q  <= '0;
            f_q    <= '0;
            nzcv_q <= '0;
        end else if (accept) begin
            ops_q  <= ops_d;
            f_q    <= f_d;
            nzcv_q <= nzcv_d;
        end
    end

    assign nzcv_live = nzcv_q;

    dp_skid_buf #(.W(PAY_W)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({ops_d, f_d, nzcv_d}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head_data)
    );

    assign {ops, f, nzcv} = head_data;

endmodule
